// File: rtl/mmu_pkg.sv
// mmu_pkg: shared MMU types and constants for the page-table-walk memory path.
package mmu_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DRAIN} arb_state_e;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int PTE_W = 64;
endpackage

// File: rtl/ptw_mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the port not granted last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);
    assign gnt_valid = |req;
    assign gnt_id    = &req ? ~last_grant : req[1];
endmodule

// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter: shares one AXI-Lite read channel between the I-side and D-side
// page-table walkers, one transaction in flight, with a data-phase watchdog.
module ptw_mem_arbiter
    import mmu_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = PTE_W,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] u0_araddr,
    input  logic              u0_arvalid,
    output logic              u0_arready,
    output logic [DATA_W-1:0] u0_rdata,
    output logic [1:0]        u0_rresp,
    output logic              u0_rvalid,
    input  logic              u0_rready,
    input  logic [ADDR_W-1:0] u1_araddr,
    input  logic              u1_arvalid,
    output logic              u1_arready,
    output logic [DATA_W-1:0] u1_rdata,
    output logic [1:0]        u1_rresp,
    output logic              u1_rvalid,
    input  logic              u1_rready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic              busy,
    output logic              grant_id,
    output logic              timeout_err
);
    arb_state_e                   state_q, state_d;
    logic [ADDR_W-1:0]            araddr_q, araddr_d;
    logic                         arvalid_q, arvalid_d;
    logic                         rready_q, rready_d;
    logic [CNT_W-1:0]             wd_q, wd_d;
    logic                         grant_q, grant_d;
    logic                         last_q, last_d;
    logic [1:0][DATA_W-1:0]       rdata_q, rdata_d;
    logic [1:0][1:0]              rresp_q, rresp_d;
    logic [1:0]                   rvalid_q, rvalid_d;
    logic                         terr_q, terr_d;
    logic                         gnt_valid, gnt_id, g_rready, idle;

    rr_arb2 u_arb (
        .req        ({u1_arvalid, u0_arvalid}),
        .last_grant (last_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign idle        = state_q == IDLE;
    assign u0_arready  = idle & gnt_valid & ~gnt_id;
    assign u1_arready  = idle & gnt_valid & gnt_id;
    assign g_rready    = grant_q ? u1_rready : u0_rready;
    assign u0_rdata    = rdata_q[0];
    assign u1_rdata    = rdata_q[1];
    assign u0_rresp    = rresp_q[0];
    assign u1_rresp    = rresp_q[1];
    assign u0_rvalid   = rvalid_q[0];
    assign u1_rvalid   = rvalid_q[1];
    assign m_araddr    = araddr_q;
    assign m_arvalid   = arvalid_q;
    assign m_rready    = rready_q;
    assign busy        = !idle;
    assign grant_id    = grant_q;
    assign timeout_err = terr_q;

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        wd_d      = wd_q;
        grant_d   = grant_q;
        last_d    = last_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rvalid_d  = rvalid_q;
        terr_d    = terr_q;
        case (state_q)
            IDLE: if (gnt_valid) begin
                araddr_d  = gnt_id ? u1_araddr : u0_araddr;
                arvalid_d = 1'b1;
                grant_d   = gnt_id;
                last_d    = gnt_id;
                state_d   = ADDR;
            end
            ADDR: if (m_arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                wd_d      = '0;
                state_d   = DATA;
            end
            DATA: if (m_rvalid) begin
                rdata_d[grant_q]  = m_rdata;
                rresp_d[grant_q]  = m_rresp;
                rvalid_d[grant_q] = 1'b1;
                rready_d          = 1'b0;
                state_d           = RESP;
            end else if (TIMEOUT != 0 && wd_q == CNT_W'(TIMEOUT - 1)) begin
                rdata_d[grant_q]  = '0;
                rresp_d[grant_q]  = RESP_SLVERR;
                rvalid_d[grant_q] = 1'b1;
                terr_d            = 1'b1;
                state_d           = DRAIN;
            end else begin
                wd_d = wd_q + CNT_W'(1);
            end
            RESP: if (g_rready) begin
                rvalid_d[grant_q] = 1'b0;
                state_d           = IDLE;
            end
            DRAIN: begin
                // m_rready low marks the late beat consumed; rvalid low marks the response taken
                if (m_rvalid) rready_d = 1'b0;
                if (g_rready) rvalid_d[grant_q] = 1'b0;
                if (!rready_d && !rvalid_d[grant_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            wd_q      <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rvalid_q  <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            wd_q      <= wd_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rvalid_q  <= rvalid_d;
            terr_q    <= terr_d;
        end
    end
endmodule
